// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) in front of the shared byte-addressable memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is data priority with fetch starvation override.
module mem_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [AWIDTH-1:0] dm_addr_i,
  input  logic [DWIDTH-1:0] dm_wdata_i,
  input  logic [2:0]        dm_funct3_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DWIDTH-1:0] dm_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  localparam logic [2:0] FUNCT3_LW = 3'b010;

  logic if_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 0 = fetch granted last, 1 = data granted last
  logic last_gnt;

  assign if_win = last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b0;
    end else if (if_gnt_o) begin
      last_gnt <= 1'b0;
    end else if (dm_gnt_o) begin
      last_gnt <= 1'b1;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign if_win = (starve_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (if_req_i && !if_gnt_o) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`endif

  // Grants are suppressed while rst is high so nothing reaches memory during reset.
  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    if (!rst) begin
      if (if_req_i && dm_req_i) begin
        if_gnt_o = if_win;
        dm_gnt_o = !if_win;
      end else begin
        if_gnt_o = if_req_i;
        dm_gnt_o = dm_req_i;
      end
    end
  end

  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_funct3_o   = 3'b000;
    if (if_gnt_o) begin
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
      mem_funct3_o  = FUNCT3_LW;
    end else if (dm_gnt_o) begin
      mem_addr_o     = dm_addr_i;
      mem_data_o     = dm_wdata_i;
      mem_read_en_o  = !dm_we_i;
      mem_write_en_o = dm_we_i;
      mem_funct3_o   = dm_funct3_i;
    end
  end

  // Response stage: one cycle after grant; rdata holds while rvalid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      if_rvalid_o <= if_gnt_o;
      dm_rvalid_o <= dm_gnt_o;
      if (if_gnt_o) begin
        if_rdata_o <= mem_data_i;
      end
      if (dm_gnt_o) begin
        dm_rdata_o <= dm_we_i ? '0 : mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a small byte-addressable memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [2:0]  dm_funct3 = 3'b010;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic [2:0]  mem_funct3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_funct3_i(dm_funct3), .dm_gnt_o(dm_gnt),
    .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_en_o(mem_re),
    .mem_write_en_o(mem_we), .mem_funct3_o(mem_funct3), .mem_data_i(mem_rdata)
  );

  // Memory model: 1 KiB window on the low address bits, combinational read, write at the edge.
  logic [7:0] mem [0:1023];
  logic [9:0] a0, a1, a2, a3;
  logic [31:0] word;

  always_comb begin
    a0 = mem_addr[9:0];
    a1 = a0 + 10'd1;
    a2 = a0 + 10'd2;
    a3 = a0 + 10'd3;
    word = {mem[a3], mem[a2], mem[a1], mem[a0]};
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{word[7]}}, word[7:0]};
      3'b001:  mem_rdata = {{16{word[15]}}, word[15:0]};
      3'b100:  mem_rdata = {24'd0, word[7:0]};
      3'b101:  mem_rdata = {16'd0, word[15:0]};
      default: mem_rdata = word;
    endcase
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]} = 32'h00500093;
    forever begin
      @(posedge clk);
      if (mem_we) begin
        mem[a0] = mem_wdata[7:0];
        if (mem_funct3 != 3'b000) mem[a1] = mem_wdata[15:8];
        if (mem_funct3 == 3'b010) begin
          mem[a2] = mem_wdata[23:16];
          mem[a3] = mem_wdata[31:24];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [9:0] fetch_pat = 10'b1010101010;  // bit i = fetch wins cycle i
`else
  logic [9:0] fetch_pat = 10'b1000010000;
`endif

  initial begin
    // Reset with both requesters active
    if_req = 1'b1; if_addr = 32'h01000000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h01000000; dm_funct3 = 3'b010;
    repeat (3) step();
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
    check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    check("rst_mem_en", {30'd0, mem_re, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);

    rst = 1'b0;
    #1;
    check("rel_dm_gnt", {31'd0, dm_gnt}, 32'd1);
    check("rel_if_gnt", {31'd0, if_gnt}, 32'd0);
    step();

    // Fetch-only read
    dm_req = 1'b0;
    check("rel_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
    check("rel_dm_rdata", dm_rdata, 32'h00500093);
    #1;
    check("f_gnt", {31'd0, if_gnt}, 32'd1);
    check("f_mem_port", {mem_addr[29:0], mem_re, mem_we}, {30'h01000000, 2'b10});
    check("f_funct3", {29'd0, mem_funct3}, 32'd2);
    step();
    if_req = 1'b0;
    check("f_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("f_rdata", if_rdata, 32'h00500093);
    check("f_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);

    // Store word then load byte unsigned from the next address
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h01000100;
    dm_wdata = 32'hDEADBEEF; dm_funct3 = 3'b010;
    #1;
    check("st_gnt", {31'd0, dm_gnt}, 32'd1);
    check("st_mem_en", {30'd0, mem_re, mem_we}, 32'd1);
    check("st_mem_data", mem_wdata, 32'hDEADBEEF);
    step();
    dm_we = 1'b0; dm_addr = 32'h01000101; dm_funct3 = 3'b100; dm_wdata = '0;
    check("st_ack_valid", {31'd0, dm_rvalid}, 32'd1);
    check("st_ack_data", dm_rdata, 32'd0);
    check("st_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    step();
    dm_req = 1'b0;
    check("lbu_valid", {31'd0, dm_rvalid}, 32'd1);
    check("lbu_data", dm_rdata, 32'h000000BE);
    step();
    check("idle_valid", {31'd0, dm_rvalid}, 32'd0);
    check("idle_hold", dm_rdata, 32'h000000BE);

    // Contention from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h01000000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h01000100; dm_funct3 = 3'b010;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("cont_if_gnt_%0d", i), {31'd0, if_gnt}, {31'd0, fetch_pat[i]});
      check($sformatf("cont_dm_gnt_%0d", i), {31'd0, dm_gnt}, {31'd0, ~fetch_pat[i]});
      step();
      check($sformatf("cont_if_rvalid_%0d", i), {31'd0, if_rvalid}, {31'd0, fetch_pat[i]});
    end
    if_req = 1'b0;

    // Async reset between a load grant and its edge; a store under reset must not land
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h01000100; dm_funct3 = 3'b010;
    #1;
    check("ar_gnt", {31'd0, dm_gnt}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_gnt_drop", {31'd0, dm_gnt}, 32'd0);
    check("ar_rdata", dm_rdata, 32'd0);
    check("ar_mem_en", {30'd0, mem_re, mem_we}, 32'd0);
    dm_we = 1'b1; dm_wdata = 32'h11111111;
    step();
    rst = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
    step();
    check("ar_no_rvalid", {31'd0, dm_rvalid}, 32'd0);
    check("ar_rdata_zero", dm_rdata, 32'd0);
    dm_req = 1'b1;
    step();
    dm_req = 1'b0;
    check("ar_store_blocked", dm_rdata, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single byte-addressable `memory` instance between the instruction-fetch stage and the load/store (memory) stage. It sits between the core pipeline and `memory`. It grants at most one access per cycle and drives the memory port combinationally. It registers the returned read data so each requester sees its response exactly one cycle after its grant.

## Interface
- `AWIDTH`, 32, address width (matches `memory`)
- `DWIDTH`, 32, data width (matches `memory`)
- `STARVE_LIMIT`, 4, consecutive denied fetch cycles before fetch is forced to win (fixed-priority mode only); legal range 1..15

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req_i`  in  1  fetch request (read-only)
- `if_addr_i`  in  AWIDTH  fetch byte address
- `if_gnt_o`  out  1  fetch granted this cycle
- `if_rvalid_o`  out  1  fetch response valid
- `if_rdata_o`  out  DWIDTH  fetch response word
- `dm_req_i`  in  1  data request
- `dm_we_i`  in  1  1 = store, 0 = load
- `dm_addr_i`  in  AWIDTH  data byte address
- `dm_wdata_i`  in  DWIDTH  store data
- `dm_funct3_i`  in  3  load/store size/sign code (`FUNCT3_*`)
- `dm_gnt_o`  out  1  data request granted this cycle
- `dm_rvalid_o`  out  1  data response valid (load data or store ack)
- `dm_rdata_o`  out  DWIDTH  load data (0 for store ack)
- `mem_addr_o`  out  AWIDTH  to `memory.addr_i`
- `mem_data_o`  out  DWIDTH  to `memory.data_i`
- `mem_read_en_o`  out  1  to `memory.read_en_i`
- `mem_write_en_o`  out  1  to `memory.write_en_i`
- `mem_funct3_o`  out  3  to `memory.funct3_i`
- `mem_data_i`  in  DWIDTH  from `memory.data_o`

## Operation
**Arbitration**
- Arbitration is combinational from the requests and the registered arbitration state.
- Grants are mutually exclusive, and a grant is only given to an asserted request.
- Single requester: granted immediately.
- Both requesting:
  - Data wins.
  - Exception: fetch wins when `starve_cnt == STARVE_LIMIT`.

**Starvation counter**
- `starve_cnt` (4 bits) increments when `if_req_i` is asserted and fetch is not granted.
- It saturates at `STARVE_LIMIT`.
- It clears when fetch is granted or `if_req_i` is low.

**Memory port**
- Fetch grant: `mem_addr_o = if_addr_i`, `mem_read_en_o = 1`, `mem_funct3_o = FUNCT3_LW`, `mem_write_en_o = 0`.
- Data grant: address, funct3 and wdata pass through.
  - `mem_read_en_o = !dm_we_i`.
  - `mem_write_en_o = dm_we_i`.
- No grant, or `rst` high: enables are 0, and addr/data/funct3 are 0.

**Response registers**
- At each rising edge, the granted requester's `rvalid` is set for one cycle. The other `rvalid` is cleared.
- Load/fetch: `rdata` captures `mem_data_i`.
- Store: `dm_rdata_o` is 0, and the write commits to memory at the same edge.
- `rdata` holds its value while `rvalid` is low.

**Requester protocol**
- A requester holds `req`, `addr`, `we`, `wdata` and `funct3` stable until it sees its `gnt`.
- Back-to-back requests are accepted every cycle, giving full throughput.

## Timing
- Grant latency: 0 cycles (same cycle as `req`) when uncontended.
- Response latency: `rvalid` is asserted exactly 1 cycle after the grant cycle.
- Worst-case fetch wait under continuous data traffic: `STARVE_LIMIT` cycles in fixed mode, 1 cycle in round-robin mode.
- Reset values (async, immediate):
  - `if_gnt_o`, `dm_gnt_o`, `if_rvalid_o`, `dm_rvalid_o`, `if_rdata_o`, `dm_rdata_o`: 0.
  - `starve_cnt`, `last_gnt`: 0.
  - All `mem_*_o`: 0.
- Reset mid-operation: any in-flight response is discarded (no `rvalid` after reset deasserts). A store granted in the same cycle `rst` rises is not issued.
- First cycle after reset deassertion: arbitration resumes normally.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On contention, the requester not granted last time wins.
  - `last_gnt` (0 = fetch, 1 = data) updates on every grant.
  - `starve_cnt` is not implemented, and `STARVE_LIMIT` is ignored.
- Undefined: fixed data priority with the starvation override described above.

## Test plan
- Reset with both reqs high, `rst`=1 for 3 cycles: all grants, rvalids and `mem_*_en` are 0. Release → data granted first cycle.
- Fetch-only read at 0x01000000 (memory word 0x00500093): `if_gnt_o`=1 same cycle; next cycle `if_rvalid_o`=1, `if_rdata_o`=0x00500093.
- Store then load: `dm_we`=1, SW 0xDEADBEEF @0x01000100, then LBU @0x01000101 next cycle.
  - Cycle 1: `dm_rvalid_o`=1 with `dm_rdata_o`=0 (store ack).
  - Cycle 2: `dm_rdata_o`=0x000000BE.
- Contention, fixed mode, `STARVE_LIMIT`=4, both reqs held 10 cycles: grant pattern D,D,D,D,F,D,D,D,D,F.
- Contention with `MEM_ARB_ROUND_ROBIN_EN`, both reqs held 6 cycles starting after reset: D,F,D,F,D,F.
- Async reset asserted mid-load (between grant and edge): no `dm_rvalid_o` follows; `dm_rdata_o` stays 0.
